// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver.
package ps2_pkg;

    // Bits per PS/2 frame: start, 8 data, parity, stop
    localparam int FRAME_BITS = 11;

    // Common scan-code prefixes
    localparam logic [7:0] SCAN_BREAK = 8'hF0;
    localparam logic [7:0] SCAN_EXT   = 8'hE0;

    typedef logic [7:0] scan_code_t;

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus a third flop for
// falling-edge detection. All flops reset to 1, the idle level of the bus.
module ps2_sync (
    input  logic clk,
    input  logic clrn,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words into scan codes and
// queues them in a small FIFO. Define PS2_PARITY_CHECK_EN to reject frames
// whose odd parity is wrong; by default the parity bit is ignored.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       ready,
    input  logic       nextdata_n,
    output logic       overflow
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic w_clk_sync_unused;
    logic w_clk_fall;
    logic w_data_sync;
    logic w_data_fall_unused;

    ps2_sync u_sync_clk (
        .clk    (clk),
        .clrn   (clrn),
        .i_line (ps2_clk),
        .o_sync (w_clk_sync_unused),
        .o_fall (w_clk_fall)
    );

    ps2_sync u_sync_data (
        .clk    (clk),
        .clrn   (clrn),
        .i_line (ps2_data),
        .o_sync (w_data_sync),
        .o_fall (w_data_fall_unused)
    );

    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_shift;    // bit 0 = start, bits 8:1 = d7..d0, bit 9 = parity
    logic [TO_W-1:0]    r_to_cnt;
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic               r_overflow;
    scan_code_t         r_mem [DEPTH];

    logic               w_last_bit;
    logic               w_frame_ok;
    logic               w_parity_ok;
    logic [FIFO_AW-1:0] w_wptr_nxt;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_last_bit = w_clk_fall && (r_bit_cnt == 4'(FRAME_BITS - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_ok = ^r_shift[9:1];
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_frame_ok = w_last_bit && !r_shift[0] && w_data_sync && w_parity_ok;

    assign w_wptr_nxt = r_wptr + 1'b1;
    assign w_full     = (w_wptr_nxt == r_rptr);
    assign ready      = (r_wptr != r_rptr);
    assign w_pop      = ready && !nextdata_n;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign w_push     = w_frame_ok && (!w_full || w_pop);
    assign w_drop     = w_frame_ok && w_full && !w_pop;

    assign data     = r_mem[r_rptr];
    assign overflow = r_overflow;

    // Bit counter, shift register and inter-edge timeout for partial frames
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_to_cnt  <= '0;
        end else if (w_clk_fall) begin
            r_to_cnt <= '0;
            if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {w_data_sync, r_shift[9:1]};
            end
        end else if (r_bit_cnt != 4'd0) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage write; contents are left untouched by reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shift[8:1];
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx. Build with +define+PS2_PARITY_CHECK_EN
// to exercise the parity-checking variant.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int  TO_CYC   = 200;
    localparam time CLK_HALF = 5ns;
    localparam time PS2_HALF = 200ns;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_keyboard_rx #(
        .FIFO_AW     (3),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .ready      (ready),
        .nextdata_n (nextdata_n),
        .overflow   (overflow)
    );

    always #CLK_HALF clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Send the first nbits of a frame; bad_par flips the odd parity bit
    task automatic send_bits(input logic [7:0] code, input bit bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            #PS2_HALF ps2_clk = 1'b0;
            #PS2_HALF ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code);
        send_bits(code, 1'b0, 11);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {7'd0, ready}, 8'd1);
    endtask

    task automatic pop();
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        #1;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        clrn       = 1'b0;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        idle(5);
        check("reset_ready", {7'd0, ready}, 8'd0);
        check("reset_ovf", {7'd0, overflow}, 8'd0);
        clrn = 1'b1;
        idle(5);

        // Pop on an empty FIFO must be ignored
        pop();
        check("empty_pop_ready", {7'd0, ready}, 8'd0);

        // Single frame
        send_frame(8'h1C);
        wait_ready("single_ready");
        check("single_data", data, 8'h1C);
        pop();
        check("single_pop_ready", {7'd0, ready}, 8'd0);

        // Break sequence F0 1C
        send_frame(SCAN_BREAK);
        send_frame(8'h1C);
        wait_ready("seq_ready");
        check("seq_data0", data, 8'hF0);
        pop();
        check("seq_data1", data, 8'h1C);
        pop();
        check("seq_empty", {7'd0, ready}, 8'd0);

        // Overflow: 8 frames into 7 usable slots
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
        idle(5);
        check("ovf_set", {7'd0, overflow}, 8'd1);
        check("ovf_head", data, 8'h10);
        pop();
        check("ovf_clear", {7'd0, overflow}, 8'd0);
        check("ovf_second", data, 8'h11);
        for (int i = 1; i <= 5; i++) begin
            pop();
            check("ovf_drain", data, 8'h11 + 8'(i));
        end
        pop();
        check("ovf_empty", {7'd0, ready}, 8'd0);

        // Parity error on 23
        send_bits(8'h23, 1'b1, 11);
        idle(10);
`ifdef PS2_PARITY_CHECK_EN
        check("par_drop_ready", {7'd0, ready}, 8'd0);
        check("par_drop_ovf", {7'd0, overflow}, 8'd0);
`else
        check("par_ign_ready", {7'd0, ready}, 8'd1);
        check("par_ign_data", data, 8'h23);
        pop();
`endif

        // Partial frame followed by timeout, then a clean frame
        send_bits(8'hFF, 1'b0, 5);
        idle(TO_CYC + 50);
        send_frame(8'h1B);
        wait_ready("to_ready");
        check("to_data", data, 8'h1B);
        pop();
        check("to_empty", {7'd0, ready}, 8'd0);

        // Reset in the middle of a frame with two entries queued
        send_frame(8'hA1);
        send_frame(8'hB2);
        wait_ready("rst_pre_ready");
        send_bits(8'h55, 1'b0, 4);
        clrn = 1'b0;
        #1;
        check("rst_ready", {7'd0, ready}, 8'd0);
        check("rst_ovf", {7'd0, overflow}, 8'd0);
        idle(3);
        clrn = 1'b1;
        idle(3);
        send_frame(8'h3C);
        wait_ready("rst_post_ready");
        check("rst_post_data", data, 8'h3C);
        pop();
        check("rst_post_empty", {7'd0, ready}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
